adder_accumulator: RTL and testbench
====================================

# adder_accumulator

Registered accumulator stage placed directly downstream of the 4-bit ripple-carry adder in the Kairos EDA demonstration datapath. It consumes each adder result as a 5-bit value {cout, sum[3:0]} through a valid/ready handshake and sums BURST_LEN accepted results into an ACC_W-bit total. It then presents the total, the number of carry-outs seen and a sticky overflow flag on a registered valid/ready output. This gives the demonstration flow a block with real sequential logic (FSM, counters, back-pressure) for synthesis and place-and-route.

## Interface
Parameters:
- ACC_W, 8, accumulator width; legal range ≥ 5.
- BURST_LEN, 4, adder results summed per output; legal range ≥ 1.
- CNT_W, 4, width of the sample counter and the carry counter; requires BURST_LEN ≤ 2^CNT_W − 1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  adder result valid.
- in_ready  out  1  stage can accept a result.
- sum  in  4  adder sum.
- cout  in  1  adder carry-out.
- out_valid  out  1  burst result valid.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W  accumulated total.
- out_carries  out  CNT_W  number of accepted samples in the burst with cout=1.
- out_ovf  out  1  sticky flag; set if any addition in the burst exceeded 2^ACC_W − 1.

## Operation
- Sample value: {cout, sum}, zero-extended to ACC_W bits (range 0..31).
- Accept: in_valid && in_ready at a rising clk edge.
- FSM states:
  - IDLE (reset state): in_ready=1. On accept: acc←sample, n←1, carries←cout, ovf←0. Next state is HOLD if BURST_LEN==1, otherwise ACCUM.
  - ACCUM: in_ready=1. On accept: acc←acc+sample, n←n+1, carries←carries+cout, ovf←ovf | carry-out of the ACC_W-bit add. When the accept makes n reach BURST_LEN, next state is HOLD. Cycles with in_valid=0 change nothing.
  - HOLD: in_ready=0, out_valid=1. Input is ignored. When out_ready=1, next state is IDLE.
- Arithmetic: the add is modulo 2^ACC_W, unless the configuration macro below enables saturation.
- out_acc, out_carries and out_ovf are registers loaded on the transition into HOLD. They hold stable for the whole HOLD state.
- Reset mid-burst: all partial state is discarded and the FSM returns to IDLE. There is no partial output.

## Timing
- Reset values: out_valid=0, out_acc=0, out_carries=0, out_ovf=0, state=IDLE, n=0.
- in_ready = (state != HOLD) && !rst. It is 0 in every cycle in which rst is high and 1 in the first cycle after rst falls.
- Latency: out_valid rises in the cycle after the BURST_LEN-th accept.
- out_valid falls in the cycle after the edge where out_valid && out_ready. in_ready is 1 in that same cycle.
- The first sample of the next burst can be accepted one cycle after the output handshake. This gives a throughput of BURST_LEN accepts per BURST_LEN+1 cycles minimum.
- Output registers remain stable while out_valid && !out_ready.
- Simultaneous rst and handshake in the same cycle: rst wins and the result is dropped.
- The block has no combinational path from in_valid to out_valid or from out_ready to in_ready. in_ready depends only on the state register and rst.

## Configuration
- Macro: ADDER_ACC_SATURATE_EN.
- Defined: when the ACC_W-bit add overflows, acc saturates to 2^ACC_W − 1 and stays there for the rest of the burst. out_ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W and out_ovf is set.
- Ports, latency and handshake are identical in both builds.

## Test plan
- Reset: hold rst high for 3 cycles while in_valid=1. Required: in_ready=0, out_valid=0, out_acc=0, out_carries=0, out_ovf=0; in_ready=1 in the cycle after rst falls.
- Basic burst (ACC_W=8, BURST_LEN=4): send {cout,sum} = (0,3), (0,5), (1,2), (0,15) back-to-back. Required: out_valid=1 one cycle after the 4th accept, out_acc=41, out_carries=1, out_ovf=0.
- Bubbles and back-pressure: insert in_valid=0 gaps between samples, then hold out_ready=0 for 5 cycles. Required: gaps do not count toward BURST_LEN; the result stays stable with in_ready=0 while stalled; out_valid falls and in_ready rises the cycle after out_ready=1.
- Overflow (ACC_W=6, BURST_LEN=4): send four samples of (1,15)=31. Required: out_acc=60 and out_ovf=1 without ADDER_ACC_SATURATE_EN; out_acc=63 and out_ovf=1 with it; out_carries=4 in both builds.
- Reset mid-burst: accept 2 samples of 7, assert rst for 1 cycle, then send 4 samples of 1. Required: out_acc=4, out_carries=0, out_ovf=0.
- BURST_LEN=1: send (1,0)=16. Required: out_valid rises the next cycle with out_acc=16 and out_carries=1.

Source files
------------

// File: rtl/adder_accumulator.sv
// Burst accumulator behind the 4-bit ripple-carry adder: sums BURST_LEN {cout,sum} samples
// and presents total, carry count and sticky overflow. Macro ADDER_ACC_SATURATE_EN selects saturating adds.
module adder_accumulator #(
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_carries,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST    = CNT_W'(BURST_LEN);
  localparam logic [ACC_W-1:0] LP_ACC_MAX = '1;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_n;
  logic [CNT_W-1:0]   r_carries;
  logic               r_ovf;
  logic [ACC_W-1:0]   r_out_acc;
  logic [CNT_W-1:0]   r_out_carries;
  logic               r_out_ovf;

  logic               w_accept;
  logic               w_last;
  logic [ACC_W-1:0]   w_sample;
  logic [ACC_W-1:0]   w_base_acc;
  logic [CNT_W-1:0]   w_base_n;
  logic [CNT_W-1:0]   w_base_car;
  logic               w_base_ovf;
  logic [ACC_W:0]     w_sum_ext;
  logic               w_add_ovf;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_n_nxt;
  logic [CNT_W-1:0]   w_car_nxt;
  logic               w_ovf_nxt;

  // Next accumulator values; IDLE starts a fresh burst from zero
  always_comb begin
    w_accept   = in_valid && in_ready;
    w_sample   = ACC_W'({cout, sum});
    w_base_acc = (r_state == S_IDLE) ? '0   : r_acc;
    w_base_n   = (r_state == S_IDLE) ? '0   : r_n;
    w_base_car = (r_state == S_IDLE) ? '0   : r_carries;
    w_base_ovf = (r_state == S_IDLE) ? 1'b0 : r_ovf;
    w_sum_ext  = {1'b0, w_base_acc} + {1'b0, w_sample};
    w_add_ovf  = w_sum_ext[ACC_W];
`ifdef ADDER_ACC_SATURATE_EN
    w_acc_nxt  = w_add_ovf ? LP_ACC_MAX : w_sum_ext[ACC_W-1:0];
`else
    w_acc_nxt  = w_sum_ext[ACC_W-1:0];
`endif
    w_n_nxt    = w_base_n + CNT_W'(1);
    w_car_nxt  = w_base_car + CNT_W'(cout);
    w_ovf_nxt  = w_base_ovf | w_add_ovf;
    w_last     = w_accept && (w_n_nxt == LP_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // BURST_LEN==1 falls out naturally: the first accept already hits LP_LAST
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_last)        w_state_nxt = S_HOLD;
        else if (w_accept) w_state_nxt = S_ACCUM;
      end
      S_HOLD: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state != S_HOLD) && !rst;
    out_valid = (r_state == S_HOLD);
  end

  // Partial sums advance on accept; result registers load only on entry to HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc         <= '0;
      r_n           <= '0;
      r_carries     <= '0;
      r_ovf         <= 1'b0;
      r_out_acc     <= '0;
      r_out_carries <= '0;
      r_out_ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc     <= w_acc_nxt;
        r_n       <= w_n_nxt;
        r_carries <= w_car_nxt;
        r_ovf     <= w_ovf_nxt;
      end
      if (w_last) begin
        r_out_acc     <= w_acc_nxt;
        r_out_carries <= w_car_nxt;
        r_out_ovf     <= w_ovf_nxt;
      end
    end
  end

  assign out_acc     = r_out_acc;
  assign out_carries = r_out_carries;
  assign out_ovf     = r_out_ovf;

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed scoreboard bench for adder_accumulator: three instances
// (8-bit/4-burst, 6-bit/4-burst, 8-bit/1-burst) sharing clk and rst.
module tb_adder_accumulator;

  typedef struct {
    int acc;
    int car;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic       a_in_valid, a_in_ready, a_cout, a_out_valid, a_out_ready, a_out_ovf;
  logic [3:0] a_sum;
  logic [7:0] a_out_acc;
  logic [3:0] a_out_carries;

  logic       b_in_valid, b_in_ready, b_cout, b_out_valid, b_out_ready, b_out_ovf;
  logic [3:0] b_sum;
  logic [5:0] b_out_acc;
  logic [3:0] b_out_carries;

  logic       c_in_valid, c_in_ready, c_cout, c_out_valid, c_out_ready, c_out_ovf;
  logic [3:0] c_sum;
  logic [7:0] c_out_acc;
  logic [3:0] c_out_carries;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];
  int samp[4];

  always #5 clk = ~clk;

  adder_accumulator #(.ACC_W(8), .BURST_LEN(4), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sum(a_sum), .cout(a_cout), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_acc(a_out_acc), .out_carries(a_out_carries), .out_ovf(a_out_ovf));

  adder_accumulator #(.ACC_W(6), .BURST_LEN(4), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sum(b_sum), .cout(b_cout), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_acc(b_out_acc), .out_carries(b_out_carries), .out_ovf(b_out_ovf));

  adder_accumulator #(.ACC_W(8), .BURST_LEN(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sum(c_sum), .cout(c_cout), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_acc(c_out_acc), .out_carries(c_out_carries), .out_ovf(c_out_ovf));

  // Integer reference: samples are {cout,sum} as 0..31
  function automatic exp_t model(input int w, input int n);
    exp_t e;
    int lim;
    int t;
    lim   = 1 << w;
    e.acc = 0;
    e.car = 0;
    e.ovf = 0;
    for (int i = 0; i < n; i++) begin
      e.car += (samp[i] >> 4) & 1;
      t = e.acc + samp[i];
      if (t >= lim) begin
        e.ovf = 1;
`ifdef ADDER_ACC_SATURATE_EN
        t = lim - 1;
`else
        t = t - lim;
`endif
      end
      e.acc = t;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0:       return a_in_ready;
      1:       return b_in_ready;
      default: return c_in_ready;
    endcase
  endfunction

  function automatic logic ovld(input int d);
    case (d)
      0:       return a_out_valid;
      1:       return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  task automatic set_in(input int d, input logic vld, input int v);
    case (d)
      0: begin a_in_valid = vld; a_sum = 4'(v); a_cout = 1'(v >> 4); end
      1: begin b_in_valid = vld; b_sum = 4'(v); b_cout = 1'(v >> 4); end
      default: begin c_in_valid = vld; c_sum = 4'(v); c_cout = 1'(v >> 4); end
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One sample through the handshake; returns 1 time unit after the accepting edge
  task automatic send(input int d, input int v);
    set_in(d, 1'b1, v);
    for (int i = 0; i < 20 && !rdy(d); i++) @(negedge clk);
    chk($sformatf("in_ready%0d", d), 32'(rdy(d)), 32'd1);
    @(posedge clk);
    #1;
    set_in(d, 1'b0, 0);
  endtask

  // Called in the cycle right after the last accept: result must already be valid
  task automatic check_out(input int d, input string tag);
    exp_t e;
    int   qs;
    logic [31:0] acc_o, car_o, ovf_o;
    chk({tag, "_valid"}, 32'(ovld(d)), 32'd1);
    case (d)
      0: begin qs = sb_a.size(); acc_o = 32'(a_out_acc); car_o = 32'(a_out_carries); ovf_o = 32'(a_out_ovf); end
      1: begin qs = sb_b.size(); acc_o = 32'(b_out_acc); car_o = 32'(b_out_carries); ovf_o = 32'(b_out_ovf); end
      default: begin qs = sb_c.size(); acc_o = 32'(c_out_acc); car_o = 32'(c_out_carries); ovf_o = 32'(c_out_ovf); end
    endcase
    chk({tag, "_sb_pending"}, 32'(qs > 0), 32'd1);
    if (qs > 0) begin
      case (d)
        0:       e = sb_a.pop_front();
        1:       e = sb_b.pop_front();
        default: e = sb_c.pop_front();
      endcase
      chk({tag, "_acc"}, acc_o, 32'(e.acc));
      chk({tag, "_carries"}, car_o, 32'(e.car));
      chk({tag, "_ovf"}, ovf_o, 32'(e.ovf));
    end
  endtask

  initial begin
    rst = 1'b1;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    c_out_ready = 1'b1;
    set_in(0, 1'b1, 5);
    set_in(1, 1'b1, 5);
    set_in(2, 1'b1, 5);

    // Reset held 3 cycles with in_valid high
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_acc", 32'(a_out_acc), 32'd0);
      chk("rst_out_carries", 32'(a_out_carries), 32'd0);
      chk("rst_out_ovf", 32'(a_out_ovf), 32'd0);
      chk("rst_c_in_ready", 32'(c_in_ready), 32'd0);
    end
    rst = 1'b0;
    set_in(0, 1'b0, 0);
    set_in(1, 1'b0, 0);
    set_in(2, 1'b0, 0);
    #1;
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("post_rst_b_in_ready", 32'(b_in_ready), 32'd1);

    // Basic back-to-back burst
    samp = '{3, 5, 18, 15};
    sb_a.push_back(model(8, 4));
    send(0, 3); send(0, 5); send(0, 18); send(0, 15);
    check_out(0, "basic");
    idle(1);
    chk("basic_valid_fall", 32'(a_out_valid), 32'd0);
    chk("basic_ready_rise", 32'(a_in_ready), 32'd1);

    // Bubbles between samples, then 5-cycle stall with input ignored
    a_out_ready = 1'b0;
    samp = '{1, 25, 0, 31};
    sb_a.push_back(model(8, 4));
    send(0, 1); idle(2);
    send(0, 25); idle(1);
    send(0, 0); idle(3);
    chk("bubble_no_early_valid", 32'(a_out_valid), 32'd0);
    send(0, 31);
    check_out(0, "bubble");
    set_in(0, 1'b1, 7);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("stall_valid", 32'(a_out_valid), 32'd1);
      chk("stall_in_ready", 32'(a_in_ready), 32'd0);
      chk("stall_acc", 32'(a_out_acc), 32'd57);
      chk("stall_carries", 32'(a_out_carries), 32'd2);
    end
    set_in(0, 1'b0, 0);
    a_out_ready = 1'b1;
    idle(1);
    chk("release_valid_fall", 32'(a_out_valid), 32'd0);
    chk("release_ready_rise", 32'(a_in_ready), 32'd1);

    // Overflow on the 6-bit instance
    samp = '{31, 31, 31, 31};
    sb_b.push_back(model(6, 4));
    send(1, 31); send(1, 31); send(1, 31); send(1, 31);
    check_out(1, "ovf");
    idle(1);
    chk("ovf_valid_fall", 32'(b_out_valid), 32'd0);

    // Reset mid-burst discards partial state
    send(0, 7); send(0, 7);
    rst = 1'b1;
    idle(1);
    chk("midrst_in_ready", 32'(a_in_ready), 32'd0);
    chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
    rst = 1'b0;
    samp = '{1, 1, 1, 1};
    sb_a.push_back(model(8, 4));
    send(0, 1); send(0, 1); send(0, 1); send(0, 1);
    check_out(0, "midrst");
    idle(1);

    // Single-sample bursts
    samp = '{16, 0, 0, 0};
    sb_c.push_back(model(8, 1));
    send(2, 16);
    check_out(2, "len1");
    idle(1);
    chk("len1_valid_fall", 32'(c_out_valid), 32'd0);
    c_out_ready = 1'b0;
    samp = '{9, 0, 0, 0};
    sb_c.push_back(model(8, 1));
    send(2, 9);
    check_out(2, "len1b");

    // Reset coinciding with output handshake wins
    c_out_ready = 1'b1;
    rst = 1'b1;
    idle(1);
    chk("rst_hs_valid", 32'(c_out_valid), 32'd0);
    chk("rst_hs_acc", 32'(c_out_acc), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_hs_in_ready", 32'(c_in_ready), 32'd1);

    chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
    chk("sb_b_drained", 32'(sb_b.size()), 32'd0);
    chk("sb_c_drained", 32'(sb_c.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
